// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer_if
//  Description : Load/ready handshake and serial output bundle for the
//                parallel-in/serial-out framer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;       // parallel word, sampled on accepted load
  logic             load;      // load request
  logic             ready;     // serializer can accept a load this cycle
  logic             sout;      // serial data
  logic             sout_vld;  // sout carries a frame bit
  logic             busy;      // frame in progress
  logic             done;      // one-cycle end-of-frame pulse

  // Producer side: offers words and observes the serial stream.
  modport master (
    output din,
    output load,
    input  ready,
    input  sout,
    input  sout_vld,
    input  busy,
    input  done
  );

  // Serializer side.
  modport slave (
    input  din,
    input  load,
    output ready,
    output sout,
    output sout_vld,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in/serial-out framer. Accepts a WIDTH-bit word on a
//                load/ready handshake and shifts it out one bit per DIV
//                clocks, MSB or LSB first. Back-to-back loads accepted in the
//                final clock of a frame continue the stream with no gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 8,    // frame width in bits (>= 2)
  parameter int DIV       = 1,    // clocks per serial bit (>= 1)
  parameter bit MSB_FIRST = 1'b1, // 1: MSB leaves first, 0: LSB first
  parameter bit IDLE_LVL  = 1'b0  // sout level outside a frame
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_bit_w = $clog2(WIDTH);
  localparam int c_div_w = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q;
  logic [WIDTH-1:0]   shift_q;     // remaining word, head bit at the exit end
  logic [c_bit_w-1:0] bit_cnt_q;   // index of the bit currently on sout
  logic [c_div_w-1:0] div_cnt_q;   // clock within the current bit period
  logic               sout_q;
  logic               sout_vld_q;
  logic               busy_q;
  logic               done_q;

  // Next-state values for the shift path and the divider.
  logic [WIDTH-1:0]   shift_d;
  logic [c_div_w-1:0] div_cnt_d;

  logic w_div_last;    // last clock of the current bit period
  logic w_bit_last;    // the final bit of the frame is on sout
  logic w_frame_end;   // final clock of the frame
  logic w_ready;
  logic w_accept;
  logic w_load_head;   // first bit of the word presented on din
  logic w_next_head;   // bit that follows the current head in shift_q

  // --------------------------------------------------------------------------
  // Bit-period divider. With DIV=1 every clock closes a bit period and the
  // counter stays at zero.
  // --------------------------------------------------------------------------
  generate
    if (DIV == 1) begin : g_div_single
      assign w_div_last = 1'b1;
      assign div_cnt_d  = '0;
    end else begin : g_div_multi
      localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV - 1);
      assign w_div_last = (div_cnt_q == c_div_last);
      assign div_cnt_d  = w_div_last ? '0 : (div_cnt_q + c_div_w'(1));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Bit ordering. shift_q always keeps the word so that the bit currently on
  // sout sits at the exit end; advancing discards it and brings the next one.
  // --------------------------------------------------------------------------
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_load_head = bus.din[WIDTH-1];
      assign w_next_head = shift_q[WIDTH-2];
      assign shift_d     = {shift_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_load_head = bus.din[0];
      assign w_next_head = shift_q[1];
      assign shift_d     = {1'b0, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Handshake. ready depends on registers only, so a producer may compute
  // load from ready in the same cycle without forming a loop.
  // --------------------------------------------------------------------------
  assign w_bit_last  = (bit_cnt_q == c_bit_last);
  assign w_frame_end = (state_q == ST_SHIFT) && w_bit_last && w_div_last;
  assign w_ready     = (state_q == ST_IDLE) || w_frame_end;
  assign w_accept    = bus.load && w_ready;

  // --------------------------------------------------------------------------
  // Framing state machine with registered outputs. Reset aborts any frame in
  // flight without a done pulse and overrides a coincident load.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      sout_q     <= IDLE_LVL;
      sout_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            state_q    <= ST_SHIFT;
            shift_q    <= bus.din;
            sout_q     <= w_load_head;
            sout_vld_q <= 1'b1;
            busy_q     <= 1'b1;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
          end
        end

        ST_SHIFT: begin
          div_cnt_q <= div_cnt_d;
          if (w_div_last) begin
            if (w_bit_last) begin
              // Frame complete: done pulses whether or not a new word follows.
              done_q    <= 1'b1;
              bit_cnt_q <= '0;
              if (w_accept) begin
                // Gapless reload: the next frame's head bit takes over sout.
                shift_q <= bus.din;
                sout_q  <= w_load_head;
              end else begin
                state_q    <= ST_IDLE;
                shift_q    <= '0;
                sout_q     <= IDLE_LVL;
                sout_vld_q <= 1'b0;
                busy_q     <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + c_bit_w'(1);
              shift_q   <= shift_d;
              sout_q    <= w_next_head;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.ready    = w_ready;
  assign bus.sout     = sout_q;
  assign bus.sout_vld = sout_vld_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Self-checking bench for piso_serializer. Two instances:
//                A = WIDTH 8, DIV 1, MSB first, idle low
//                B = WIDTH 8, DIV 3, LSB first, idle high
//                Directed vector table, hand-written corner sequences and a
//                randomized run, all checked against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_piso_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rs [2];
  logic         ld [2];
  logic [W-1:0] dn [2];

  piso_serializer_if #(.WIDTH(W)) if_a ();
  piso_serializer_if #(.WIDTH(W)) if_b ();

  assign if_a.load = ld[0];
  assign if_a.din  = dn[0];
  assign if_b.load = ld[1];
  assign if_b.din  = dn[1];

  piso_serializer #(.WIDTH(W), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u_a (
    .clk (clk),
    .rst (rs[0]),
    .bus (if_a)
  );

  piso_serializer #(.WIDTH(W), .DIV(3), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) u_b (
    .clk (clk),
    .rst (rs[1]),
    .bus (if_b)
  );

  int checks   = 0;
  int failures = 0;

  // Simple downstream detector on instance A: pulses one cycle after the
  // second of two equal consecutive valid bits, then starts a new pair.
  logic det_have, det_prev, det;
  always_ff @(posedge clk) begin
    if (rs[0]) begin
      det_have <= 1'b0;
      det_prev <= 1'b0;
      det      <= 1'b0;
    end else begin
      det <= 1'b0;
      if (if_a.sout_vld) begin
        if (det_have && (if_a.sout == det_prev)) begin
          det      <= 1'b1;
          det_have <= 1'b0;
        end else begin
          det_have <= 1'b1;
          det_prev <= if_a.sout;
        end
      end
    end
  end

  // ---------------- configuration of each instance ----------------
  function automatic int div_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction
  function automatic logic msb_of(int k);
    return (k == 0) ? 1'b1 : 1'b0;
  endfunction
  function automatic logic idle_of(int k);
    return (k == 0) ? 1'b0 : 1'b1;
  endfunction

  // Observed outputs packed as {sout, sout_vld, busy, ready, done}.
  function automatic logic [4:0] outs(int k);
    if (k == 0) return {if_a.sout, if_a.sout_vld, if_a.busy, if_a.ready, if_a.done};
    return {if_b.sout, if_b.sout_vld, if_b.busy, if_b.ready, if_b.done};
  endfunction

  // ---------------- frame-level reference model ----------------
  // rem = clocks of the current frame still to be shown (including this one).
  int           rem     [2];
  logic [W-1:0] word    [2];
  logic         done_e  [2];

  function automatic logic [4:0] model_outs(int k);
    int   c;
    int   i;
    logic b;
    if (rem[k] > 0) begin
      c = W * div_of(k) - rem[k];
      i = c / div_of(k);
      b = msb_of(k) ? word[k][W-1-i] : word[k][i];
      return {b, 1'b1, 1'b1, (rem[k] <= 1), done_e[k]};
    end
    return {idle_of(k), 1'b0, 1'b0, 1'b1, done_e[k]};
  endfunction

  task automatic model_step(int k);
    logic acc;
    if (rs[k]) begin
      rem[k]    = 0;
      done_e[k] = 1'b0;
    end else begin
      acc       = ld[k] && (rem[k] <= 1);
      done_e[k] = (rem[k] == 1);
      if (rem[k] > 0) rem[k] = rem[k] - 1;
      if (acc) begin
        rem[k]  = W * div_of(k);
        word[k] = dn[k];
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock with the inputs currently driven, then compare both
  // instances with the model away from the active edge.
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    chk("model_a", 32'(outs(0)), 32'(model_outs(0)));
    chk("model_b", 32'(outs(1)), 32'(model_outs(1)));
  endtask

  task automatic idle(int n);
    for (int j = 0; j < 2; j++) begin
      ld[j] = 1'b0;
      rs[j] = 1'b0;
    end
    for (int j = 0; j < n; j++) tick();
  endtask

  // ---------------- directed vector table for instance A ----------------
  typedef struct packed {
    logic         load;
    logic [W-1:0] din;
    logic [4:0]   exp;   // {sout, sout_vld, busy, ready, done}
  } vec_t;

  function automatic vec_t mk(logic l, logic [W-1:0] d, logic [4:0] e);
    vec_t v;
    v.load = l;
    v.din  = d;
    v.exp  = e;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [W-1:0] stream;
    logic [10:0]  mask;
    int           rdy_cnt;
    int           done_cnt;
    int           done_at;
    logic [3:0]   b_bits;

    // Frame of 8'hB4, MSB first: 1,0,1,1,0,1,0,0 on cycles 1-8, done on 9.
    tbl.push_back(mk(1'b1, 8'hB4, 5'b00010));
    tbl.push_back(mk(1'b0, 8'h00, 5'b11100));
    tbl.push_back(mk(1'b0, 8'h00, 5'b01100));
    tbl.push_back(mk(1'b0, 8'h00, 5'b11100));
    tbl.push_back(mk(1'b0, 8'h00, 5'b11100));
    tbl.push_back(mk(1'b0, 8'h00, 5'b01100));
    tbl.push_back(mk(1'b0, 8'h00, 5'b11100));
    tbl.push_back(mk(1'b0, 8'h00, 5'b01100));
    tbl.push_back(mk(1'b0, 8'h00, 5'b01110));
    tbl.push_back(mk(1'b0, 8'h00, 5'b00011));
    tbl.push_back(mk(1'b0, 8'h00, 5'b00010));
    // Back-to-back 8'hFF then 8'h00: gapless, done on cycles 9 and 17.
    tbl.push_back(mk(1'b1, 8'hFF, 5'b00010));
    for (int j = 1; j <= 7; j++) tbl.push_back(mk(1'b0, 8'h00, 5'b11100));
    tbl.push_back(mk(1'b1, 8'h00, 5'b11110));
    tbl.push_back(mk(1'b0, 8'h00, 5'b01101));
    for (int j = 10; j <= 15; j++) tbl.push_back(mk(1'b0, 8'h00, 5'b01100));
    tbl.push_back(mk(1'b0, 8'h00, 5'b01110));
    tbl.push_back(mk(1'b0, 8'h00, 5'b00011));
    tbl.push_back(mk(1'b0, 8'h00, 5'b00010));

    for (int k = 0; k < 2; k++) begin
      rs[k] = 1'b1; ld[k] = 1'b0; dn[k] = '0;
      rem[k] = 0; word[k] = '0; done_e[k] = 1'b0;
    end

    // Reset state
    tick();
    tick();
    chk("reset_a", 32'(outs(0)), 32'(5'b00010));
    chk("reset_b", 32'(outs(1)), 32'(5'b10010));
    idle(2);

    // Table-driven vectors on A
    for (int i = 0; i < tbl.size(); i++) begin
      ld[0] = tbl[i].load;
      dn[0] = tbl[i].din;
      chk($sformatf("vec%0d", i), 32'(outs(0)), 32'(tbl[i].exp));
      tick();
    end
    idle(2);

    // Load during a frame is ignored: stream must be 8'hF0 only.
    ld[0] = 1'b1; dn[0] = 8'hF0;
    tick();
    stream = '0; rdy_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      ld[0] = (c == 3);
      dn[0] = (c == 3) ? 8'h55 : 8'h00;
      stream = {stream[W-2:0], if_a.sout};
      if (c <= 7 && if_a.ready) rdy_cnt++;
      tick();
    end
    chk("ignored_load_stream", 32'(stream), 32'(8'hF0));
    chk("ignored_load_ready", 32'(rdy_cnt), 32'(0));
    idle(3);

    // Reset in the middle of a frame, then a fresh frame.
    ld[0] = 1'b1; dn[0] = 8'hC3;
    tick();
    ld[0] = 1'b0;
    tick(); tick(); tick();
    rs[0] = 1'b1;
    tick();
    chk("rst_mid_outs", 32'(outs(0)), 32'(5'b00010));
    rs[0] = 1'b0;
    tick();
    chk("rst_mid_no_done", 32'(if_a.done), 32'(0));
    ld[0] = 1'b1; dn[0] = 8'hA5;
    tick();
    ld[0] = 1'b0;
    stream = '0;
    for (int c = 1; c <= 8; c++) begin
      stream = {stream[W-2:0], if_a.sout};
      tick();
    end
    chk("after_rst_stream", 32'(stream), 32'(8'hA5));
    chk("after_rst_done", 32'(if_a.done), 32'(1));
    idle(2);

    // Reset and load together: reset wins, nothing starts.
    rs[0] = 1'b1; ld[0] = 1'b1; dn[0] = 8'hFF;
    tick();
    chk("rst_load_same", 32'(outs(0)), 32'(5'b00010));
    rs[0] = 1'b0; ld[0] = 1'b0;
    tick();
    chk("rst_load_after", 32'(outs(0)), 32'(5'b00010));

    // Instance B: DIV=3, LSB first, 8'h81.
    ld[1] = 1'b1; dn[1] = 8'h81;
    tick();
    ld[1] = 1'b0;
    done_cnt = 0; done_at = -1; b_bits = '0;
    for (int c = 1; c <= 27; c++) begin
      if (if_b.done) begin
        done_cnt++;
        done_at = c;
      end
      if (c == 3)  b_bits[3] = if_b.sout;
      if (c == 4)  b_bits[2] = if_b.sout;
      if (c == 21) b_bits[1] = if_b.sout;
      if (c == 22) b_bits[0] = if_b.sout;
      tick();
    end
    chk("b_sample_bits", 32'(b_bits), 32'(4'b1001));
    chk("b_done_count", 32'(done_cnt), 32'(1));
    chk("b_done_cycle", 32'(done_at), 32'(25));

    // Integration: detector driven by A's stream of 8'b11001100.
    rs[0] = 1'b1;
    tick();
    rs[0] = 1'b0;
    ld[0] = 1'b1; dn[0] = 8'hCC;
    mask = '0;
    mask[0] = det;
    tick();
    ld[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      mask[c] = det;
      tick();
    end
    chk("detector_pulses", 32'(mask), 32'(11'h2A8));
    idle(2);

    // Randomized traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        rs[k] = ($urandom_range(0, 63) == 0);
        ld[k] = ($urandom_range(0, 2) != 0);
        dn[k] = W'($urandom);
      end
      tick();
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
